ycbcr_level_shift_stream: RTL

- Streaming colour-space front end for the JPEG path.
- Accepts packed RGB pixels over a valid/ready stream and converts each to level-shifted signed Y, and optionally Cb/Cr, in a fixed-point pipeline.
- Generates block-boundary tlast every BLOCK_PIXELS beats and flags misaligned input tlast.
- Sits between the pixel source/frame buffer and dct_block, and honours downstream backpressure fully.

---
 rtl/ycbcr_level_shift_stream.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ycbcr_level_shift_stream.sv
// RGB to level-shifted YCbCr streaming front end for the JPEG path.
// Three pipeline stages (multiply, sum+round, shift/clamp/level-shift) share
// one advance enable so a stalled output freezes the whole pipe in place.
// A beat counter tags the last pixel of every block; that tag rides along
// with the data and becomes m_axis_tlast at the output.
module ycbcr_level_shift_stream #(
    parameter int PIX_W        = 8,
    parameter int CHROMA_EN    = 0,
    parameter int BLOCK_PIXELS = 64,
    parameter int CNT_W        = 16
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [3*PIX_W-1:0]                        s_axis_tdata,
    input  logic                                      s_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [((CHROMA_EN != 0) ? 3 : 1)*PIX_W-1:0] m_axis_tdata,
    output logic                                      m_axis_tlast,
    output logic [CNT_W-1:0]                          block_count,
    output logic                                      align_err
);

    localparam int SW = PIX_W + 12;
    localparam int BW = $clog2(BLOCK_PIXELS);

    localparam logic [BW-1:0]        LAST_BEAT = BW'(BLOCK_PIXELS - 1);
    localparam logic signed [SW-1:0] RND       = SW'(512);
    localparam logic signed [SW-1:0] HALF      = SW'(1 <<< (PIX_W - 1));
    localparam logic signed [SW-1:0] SAT_HI    = HALF - SW'(1);
    localparam logic signed [SW-1:0] SAT_LO    = -HALF;

    localparam logic signed [SW-1:0] C_YR  = SW'(306);
    localparam logic signed [SW-1:0] C_YG  = SW'(601);
    localparam logic signed [SW-1:0] C_YB  = SW'(116);

    // Drop the 10 fractional bits and move Y from [0, 2^PIX_W) to signed range.
    function automatic logic signed [PIX_W-1:0] level_shift_y(input logic signed [SW-1:0] sum);
        return PIX_W'((sum >>> 10) - HALF);
    endfunction

    // Floor-shift a chroma sum and saturate it to the signed output range.
    function automatic logic signed [PIX_W-1:0] sat_chroma(input logic signed [SW-1:0] sum);
        logic signed [SW-1:0] s;
        s = sum >>> 10;
        if (s > SAT_HI) begin
            return PIX_W'(SAT_HI);
        end else if (s < SAT_LO) begin
            return PIX_W'(SAT_LO);
        end else begin
            return PIX_W'(s);
        end
    endfunction

    logic                 w_adv;
    logic                 w_acc;
    logic                 w_at_last;
    logic signed [SW-1:0] w_r;
    logic signed [SW-1:0] w_g;
    logic signed [SW-1:0] w_b;

    logic [BW-1:0]        r_beat;
    logic                 r_vld_p0, r_vld_p1, r_vld_p2;
    logic                 r_last_p0, r_last_p1, r_last_p2;
    logic [CNT_W-1:0]     r_blk_cnt;
    logic                 r_align_err;

    logic signed [SW-1:0]    r_yr_p0, r_yg_p0, r_yb_p0;
    logic signed [SW-1:0]    r_ysum_p1;
    logic signed [PIX_W-1:0] r_y_p2;

    // Output valid low means the output register is free, so the pipe may move.
    assign w_adv         = m_axis_tready | ~r_vld_p2;
    assign s_axis_tready = w_adv & ~rst_in;
    assign w_acc         = s_axis_tvalid & s_axis_tready;
    assign w_at_last     = (r_beat == LAST_BEAT);

    assign w_r = $signed({{(SW-PIX_W){1'b0}}, s_axis_tdata[3*PIX_W-1 -: PIX_W]});
    assign w_g = $signed({{(SW-PIX_W){1'b0}}, s_axis_tdata[2*PIX_W-1 -: PIX_W]});
    assign w_b = $signed({{(SW-PIX_W){1'b0}}, s_axis_tdata[PIX_W-1 -: PIX_W]});

    // Control path: valids, block-end tags, beat counter, block count, sticky error.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_last_p0   <= 1'b0;
            r_last_p1   <= 1'b0;
            r_last_p2   <= 1'b0;
            r_beat      <= '0;
            r_blk_cnt   <= '0;
            r_align_err <= 1'b0;
        end else begin
            if (w_adv) begin
                // input -> p0
                r_vld_p0  <= w_acc;
                r_last_p0 <= w_acc & w_at_last;
                // p0 -> p1
                r_vld_p1  <= r_vld_p0;
                r_last_p1 <= r_last_p0;
                // p1 -> p2
                r_vld_p2  <= r_vld_p1;
                r_last_p2 <= r_last_p1;
            end
            if (w_acc) begin
                r_beat <= w_at_last ? '0 : r_beat + 1'b1;
                if (s_axis_tlast != w_at_last) begin
                    r_align_err <= 1'b1;
                end
            end
            if (r_vld_p2 && m_axis_tready && r_last_p2) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    // Luma multiply and sum stages; these carry no reset since valids qualify them.
    always_ff @(posedge clk_in) begin
        if (w_adv) begin
            // input -> p0: products
            r_yr_p0   <= w_r * C_YR;
            r_yg_p0   <= w_g * C_YG;
            r_yb_p0   <= w_b * C_YB;
            // p0 -> p1: sum with rounding constant
            r_ysum_p1 <= r_yr_p0 + r_yg_p0 + r_yb_p0 + RND;
        end
    end

    // Luma output stage; cleared on reset so the output bus starts at zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_y_p2 <= '0;
        end else if (w_adv) begin
            // p1 -> p2: shift and level-shift
            r_y_p2 <= level_shift_y(r_ysum_p1);
        end
    end

    generate
        if (CHROMA_EN != 0) begin : g_chroma
            localparam logic signed [SW-1:0] C_CBR = -SW'(173);
            localparam logic signed [SW-1:0] C_CBG = -SW'(339);
            localparam logic signed [SW-1:0] C_CBB = SW'(512);
            localparam logic signed [SW-1:0] C_CRR = SW'(512);
            localparam logic signed [SW-1:0] C_CRG = -SW'(429);
            localparam logic signed [SW-1:0] C_CRB = -SW'(83);

            logic signed [SW-1:0]    r_cbr_p0, r_cbg_p0, r_cbb_p0;
            logic signed [SW-1:0]    r_crr_p0, r_crg_p0, r_crb_p0;
            logic signed [SW-1:0]    r_cbsum_p1, r_crsum_p1;
            logic signed [PIX_W-1:0] r_cb_p2, r_cr_p2;

            // Chroma multiply and sum stages, advancing in lockstep with luma.
            always_ff @(posedge clk_in) begin
                if (w_adv) begin
                    // input -> p0: products
                    r_cbr_p0   <= w_r * C_CBR;
                    r_cbg_p0   <= w_g * C_CBG;
                    r_cbb_p0   <= w_b * C_CBB;
                    r_crr_p0   <= w_r * C_CRR;
                    r_crg_p0   <= w_g * C_CRG;
                    r_crb_p0   <= w_b * C_CRB;
                    // p0 -> p1: sums with rounding constant
                    r_cbsum_p1 <= r_cbr_p0 + r_cbg_p0 + r_cbb_p0 + RND;
                    r_crsum_p1 <= r_crr_p0 + r_crg_p0 + r_crb_p0 + RND;
                end
            end

            // Chroma output stage with saturation; cleared on reset.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_cb_p2 <= '0;
                    r_cr_p2 <= '0;
                end else if (w_adv) begin
                    // p1 -> p2: floor shift and clamp
                    r_cb_p2 <= sat_chroma(r_cbsum_p1);
                    r_cr_p2 <= sat_chroma(r_crsum_p1);
                end
            end

            assign m_axis_tdata = {r_cr_p2, r_cb_p2, r_y_p2};
        end else begin : g_luma_only
            assign m_axis_tdata = r_y_p2;
        end
    endgenerate

    assign m_axis_tvalid = r_vld_p2;
    assign m_axis_tlast  = r_last_p2;
    assign block_count   = r_blk_cnt;
    assign align_err     = r_align_err;

endmodule
